// File: rtl/misao_pkg.sv
// misao_pkg
// Shared definitions for the misao instruction-fetch front end.
//   ADDR_W        byte address width of the program memory bus
//   NIB_PC_W      nibble program counter width ({byte_addr, hi_sel})
//   OP_*          4-bit opcode values seen by decode (bench decode only)
//   fetch_entry_t one prefetched byte together with its byte address
//   cnt_width()   bit width needed to hold an occupancy count 0..depth

package misao_pkg;

    localparam int ADDR_W   = 15;
    localparam int NIB_PC_W = ADDR_W + 1;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_CAL = 4'hC;
    localparam logic [3:0] OP_RET = 4'hD;
    localparam logic [3:0] OP_SHF = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/misao_byte_fifo.sv
// misao_byte_fifo
// Synchronous prefetch FIFO of fetch_entry_t (byte address + data).
//   clk, rst    clock (rising edge) / asynchronous active-low reset
//   push        write push_entry at the tail
//   push_entry  entry to write
//   pop         discard the head entry (caller guarantees non-empty)
//   flush       empty the FIFO; wins over push and pop in the same cycle
//   head        current head entry (meaningless while empty)
//   count       number of valid entries
//   full/empty  occupancy flags
// DEPTH must be a power of two so the pointers wrap by truncation.

module misao_byte_fifo
    import misao_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;

    // Storage carries no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; a flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/misao_nibble_fetch.sv
// misao_nibble_fetch
// Instruction-fetch front end: reads program bytes over the 8-bit memory bus
// into a small prefetch FIFO and hands decode one nibble per handshake, low
// nibble of each byte first. Handles redirects and yields the bus to XMEM.
//   clk, rst          clock (rising edge) / asynchronous active-low reset
//   bus_free          no data-side access this cycle, fetch may read
//   mem_enable_read   fetch read strobe
//   mem_addr          byte address of the fetch read (0 when not reading)
//   mem_data_in       read data, valid the cycle after mem_enable_read
//   nib_valid         nib_data / nib_pc valid
//   nib_ready         decode accepts the nibble
//   nib_data          current nibble
//   nib_pc            nibble address {byte_addr, hi_sel}
//   redirect_valid    branch / jump / reset-vector taken this cycle
//   redirect_pc       target nibble address
// ADDR_W must match misao_pkg::ADDR_W because FIFO entries are typed by it.

module misao_nibble_fetch #(
    parameter int              FIFO_DEPTH = 2,
    parameter int              ADDR_W     = 15,
    parameter logic [ADDR_W:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_free,
    output logic              mem_enable_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data_in,
    output logic              nib_valid,
    input  logic              nib_ready,
    output logic [3:0]        nib_data,
    output logic [ADDR_W:0]   nib_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W:0]   redirect_pc
);

    import misao_pkg::*;

    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] next_byte_addr;
    logic [ADDR_W-1:0] in_flight_addr;
    logic              in_flight;
    logic              hi_sel;

    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              push;
    logic              accept;
    logic              pop;

    // A read is only issued while the buffered bytes plus the byte on its way
    // back still leave a free slot, so the returning byte can never overflow.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight};

    // rst gates the strobe so it is low during reset even with bus_free high.
    assign issue = rst && bus_free && !redirect_valid && !fifo_full
                   && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    assign mem_enable_read = issue;
    assign mem_addr        = issue ? fetch_addr : '0;

    // Read data returns one cycle after issue; a redirect in that return
    // cycle flushes the FIFO, which also swallows the stale byte.
    assign push       = in_flight;
    assign push_entry = '{addr: in_flight_addr, data: mem_data_in};

    assign nib_valid = !fifo_empty && !redirect_valid;
    assign accept    = nib_valid && nib_ready;
    assign pop       = accept && hi_sel;

    assign nib_data = fifo_empty ? 4'h0 : (hi_sel ? head.data[7:4] : head.data[3:0]);
    // While empty the head address is stale, so report the next byte to deliver.
    assign nib_pc   = fifo_empty ? {next_byte_addr, hi_sel} : {head.addr, hi_sel};

    misao_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Fetch pointer, delivery pointer and nibble select. A redirect overrides
    // everything; a later redirect simply overwrites an earlier target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr     <= RESET_PC[ADDR_W:1];
            next_byte_addr <= RESET_PC[ADDR_W:1];
            hi_sel         <= RESET_PC[0];
            in_flight      <= 1'b0;
            in_flight_addr <= '0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                in_flight_addr <= fetch_addr;
            end
            if (redirect_valid) begin
                fetch_addr     <= redirect_pc[ADDR_W:1];
                next_byte_addr <= redirect_pc[ADDR_W:1];
                hi_sel         <= redirect_pc[0];
            end else begin
                if (issue) begin
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                end
                if (accept) begin
                    hi_sel <= !hi_sel;
                    if (hi_sel) begin
                        next_byte_addr <= next_byte_addr + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_misao_nibble_fetch.sv
// tb_misao_nibble_fetch
// Scoreboard bench for misao_nibble_fetch. The program memory lives here and
// answers reads one cycle later. Whenever the bench starts a stream (reset or
// redirect) it queues the nibbles that stream must produce, computed straight
// from memory and the nibble address; a monitor pops one per accepted nibble.

module tb_misao_nibble_fetch;

    localparam int              FIFO_DEPTH = 2;
    localparam int              AW         = 15;
    localparam logic [AW:0]     RESET_PC   = 16'h0000;
    localparam int              WINDOW     = 512;

    typedef struct packed {
        logic [15:0] pc;
        logic [3:0]  nib;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          bus_free;
    logic          mem_enable_read;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data_in;
    logic          nib_valid;
    logic          nib_ready;
    logic [3:0]    nib_data;
    logic [AW:0]   nib_pc;
    logic          redirect_valid;
    logic [AW:0]   redirect_pc;

    logic [7:0]    mem [0:32767];
    exp_t          exp_q [$];
    int            errors  = 0;
    int            checks  = 0;
    int            accepts = 0;

    misao_nibble_fetch #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (AW),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus_free        (bus_free),
        .mem_enable_read (mem_enable_read),
        .mem_addr        (mem_addr),
        .mem_data_in     (mem_data_in),
        .nib_valid       (nib_valid),
        .nib_ready       (nib_ready),
        .nib_data        (nib_data),
        .nib_pc          (nib_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    // Program memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_enable_read === 1'b1) begin
            mem_data_in <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_nibble(input logic [15:0] pc);
        logic [7:0] b;
        b = mem[pc[15:1]];
        return pc[0] ? b[7:4] : b[3:0];
    endfunction

    // The stream starting at a nibble address is simply consecutive nibble
    // addresses (16-bit wrap) read out of memory.
    task automatic load_expectations(input logic [15:0] start);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < WINDOW; i++) begin
            e.pc  = start + 16'(i);
            e.nib = ref_nibble(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic bf, input logic rdy, input logic rv, input logic [15:0] rpc);
        bus_free       = bf;
        nib_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) begin
            load_expectations(rpc);
        end
    endtask

    // Monitor: every accepted nibble must be the next one the model expects.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (redirect_valid === 1'b1) begin
                checkOutput("redirect_blocks_valid", {31'd0, nib_valid}, 32'd0);
                checkOutput("redirect_blocks_read", {31'd0, mem_enable_read}, 32'd0);
            end
            if (nib_valid === 1'b1 && nib_ready === 1'b1) begin
                exp_t e;
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got nibble pc %0h expected no nibble", nib_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_pc", {16'd0, nib_pc}, {16'd0, e.pc});
                    checkOutput("sb_data", {28'd0, nib_data}, {28'd0, e.nib});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reads;
        int a0;
        bit found;
        logic [15:0] rpc;
        logic rv;

        for (int a = 0; a < 32768; a++) begin
            mem[a] = 8'($urandom);
        end
        mem[0]        = 8'h18;
        mem[1]        = 8'h0C;
        mem[2]        = 8'h94;
        mem[4]        = 8'h2B;
        mem[15'h7FFF] = 8'hA5;

        mem_data_in    = 8'h00;
        rst            = 1'b1;
        bus_free       = 1'b0;
        nib_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        load_expectations(RESET_PC);
        #1 rst = 1'b0;
        #2;

        // Reset values
        checkOutput("rst_read", {31'd0, mem_enable_read}, 32'd0);
        checkOutput("rst_addr", {17'd0, mem_addr}, 32'd0);
        checkOutput("rst_valid", {31'd0, nib_valid}, 32'd0);
        checkOutput("rst_data", {28'd0, nib_data}, 32'd0);
        checkOutput("rst_pc", {16'd0, nib_pc}, {16'd0, RESET_PC});
        repeat (2) tick();

        // Linear fetch: issue in cycle 0, first nibble in cycle 2, then every cycle
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("lin_issue0", {31'd0, mem_enable_read}, 32'd1);
        checkOutput("lin_addr0", {17'd0, mem_addr}, 32'd0);
        tick(); #1;
        checkOutput("lin_addr1", {17'd0, mem_addr}, 32'd1);
        checkOutput("lin_not_yet", {31'd0, nib_valid}, 32'd0);
        for (int c = 2; c < 8; c++) begin
            tick(); #1;
            checkOutput("lin_valid", {31'd0, nib_valid}, 32'd1);
        end

        // Backpressure after a redirect to 0: only FIFO_DEPTH reads, head held
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000);
        #1;
        checkOutput("bp_redirect_nv", {31'd0, nib_valid}, 32'd0);
        reads = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
            #1;
            if (mem_enable_read) reads++;
            if (i >= 2) checkOutput("bp_hold_data", {28'd0, nib_data}, 32'h8);
        end
        checkOutput("bp_reads", reads, FIFO_DEPTH);

        // Release, 3 accepts, then redirect to odd nibble 0x0009 with a read in flight
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        tick(); #1;
        checkOutput("pre_redir_issue", {31'd0, mem_enable_read}, 32'd1);
        checkOutput("pre_redir_addr", {17'd0, mem_addr}, 32'd2);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0009);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("odd_issue", {31'd0, mem_enable_read}, 32'd1);
        checkOutput("odd_addr", {17'd0, mem_addr}, 32'd4);
        tick(); #1;
        checkOutput("odd_not_yet", {31'd0, nib_valid}, 32'd0);
        tick(); #1;
        checkOutput("odd_valid", {31'd0, nib_valid}, 32'd1);
        checkOutput("odd_data", {28'd0, nib_data}, 32'h2);
        checkOutput("odd_pc", {16'd0, nib_pc}, 32'h0009);
        repeat (3) tick();

        // Bus contention: no reads for 5 cycles, buffered nibbles still drain
        a0 = accepts;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("busy_no_read", {31'd0, mem_enable_read}, 32'd0);
            tick();
        end
        checkOutput("busy_drained", {31'd0, accepts > a0}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        a0 = accepts;
        repeat (20) tick();
        checkOutput("busy_resumed", {31'd0, (accepts - a0) >= 10}, 32'd1);

        // Two redirects back to back: the second target wins
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0101);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        tick(); #1;
        checkOutput("b2b_valid", {31'd0, nib_valid}, 32'd1);
        checkOutput("b2b_pc", {16'd0, nib_pc}, 32'h0101);
        repeat (5) tick();

        // Address wrap at the top of memory
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFE);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        #1;
        checkOutput("wrap_addr", {17'd0, mem_addr}, 32'h7FFF);
        tick(); #1;
        checkOutput("wrap_addr0", {17'd0, mem_addr}, 32'h0000);
        tick(); #1;
        checkOutput("wrap_data_lo", {28'd0, nib_data}, 32'h5);
        checkOutput("wrap_pc_lo", {16'd0, nib_pc}, 32'hFFFE);
        tick(); #1;
        checkOutput("wrap_data_hi", {28'd0, nib_data}, 32'hA);
        checkOutput("wrap_pc_hi", {16'd0, nib_pc}, 32'hFFFF);
        tick(); #1;
        checkOutput("wrap_data_0", {28'd0, nib_data}, 32'h8);
        checkOutput("wrap_pc_0", {16'd0, nib_pc}, 32'h0000);

        // Random traffic: bus contention, backpressure and redirects
        a0 = accepts;
        for (int i = 0; i < 300; i++) begin
            tick();
            rv  = ($urandom_range(0, 24) == 0);
            rpc = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 3) == 0) rpc = 16'hFFFE;
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), rv, rpc);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("rand_progress", {31'd0, accepts > a0}, 32'd1);

        // Async reset between edges with a read in flight
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0100);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_enable_read) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("arst_read_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        load_expectations(RESET_PC);
        #1;
        checkOutput("arst_read", {31'd0, mem_enable_read}, 32'd0);
        checkOutput("arst_addr", {17'd0, mem_addr}, 32'd0);
        checkOutput("arst_valid", {31'd0, nib_valid}, 32'd0);
        checkOutput("arst_data", {28'd0, nib_data}, 32'd0);
        checkOutput("arst_pc", {16'd0, nib_pc}, {16'd0, RESET_PC});
        repeat (2) tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("arst_first_issue", {31'd0, mem_enable_read}, 32'd1);
        checkOutput("arst_first_addr", {17'd0, mem_addr}, 32'd0);
        tick(); #1;
        checkOutput("arst_no_stale", {31'd0, nib_valid}, 32'd0);
        tick(); #1;
        checkOutput("arst_valid2", {31'd0, nib_valid}, 32'd1);
        checkOutput("arst_data2", {28'd0, nib_data}, 32'h8);
        checkOutput("arst_pc2", {16'd0, nib_pc}, 32'h0000);
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
